// File: rtl/dram_seq_pkg.sv
// rtl/dram_seq_pkg.sv - state encoding, phase codes and width defaults for the DRAM access sequencer
package dram_seq_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [2:0] {
      S_LOAD      = 3'd0,
      S_RUN       = 3'd1,
      S_DUMP_ADDR = 3'd2,
      S_DUMP_WAIT = 3'd3,
      S_DUMP_SEND = 3'd4,
      S_DUMP_GAP  = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   localparam logic [1:0] PH_LOAD = 2'b00;
   localparam logic [1:0] PH_RUN  = 2'b01;
   localparam logic [1:0] PH_DUMP = 2'b10;
   localparam logic [1:0] PH_DONE = 2'b11;

   function automatic logic [1:0] phase_of(input state_t s);
      case (s)
         S_LOAD:  phase_of = PH_LOAD;
         S_RUN:   phase_of = PH_RUN;
         S_DONE:  phase_of = PH_DONE;
         default: phase_of = PH_DUMP;
      endcase
   endfunction

endpackage

// File: rtl/dram_port_mux.sv
// rtl/dram_port_mux.sv - combinational DRAM port selection between receiver, processor and dump reader
module dram_port_mux
   import dram_seq_pkg::*;
#(
   parameter int               ADDR_W    = DEF_ADDR_W,
   parameter int               DATA_W    = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] LOAD_BASE = '0,
   parameter logic [ADDR_W-1:0] DUMP_BASE = '0
) (
   input  state_t              state,
   input  logic [ADDR_W-1:0]   ptr,
   input  logic                rx_valid,
   input  logic [DATA_W-1:0]   rx_data,
   input  logic [ADDR_W-1:0]   proc_address,
   input  logic [DATA_W-1:0]   proc_wdata,
   input  logic                proc_wren,
   output logic [ADDR_W-1:0]   dram_address,
   output logic [DATA_W-1:0]   dram_data,
   output logic                dram_wren
);

   // Dump and done states read only; address sums wrap modulo 2^ADDR_W.
   always_comb begin
      dram_address = DUMP_BASE + ptr;
      dram_data    = '0;
      dram_wren    = 1'b0;
      unique case (state)
         S_LOAD: begin
            dram_address = LOAD_BASE + ptr;
            dram_data    = rx_data;
            dram_wren    = rx_valid;
         end
         S_RUN: begin
            dram_address = proc_address;
            dram_data    = proc_wdata;
            dram_wren    = proc_wren;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/dram_access_sequencer.sv
// rtl/dram_access_sequencer.sv - LOAD/RUN/DUMP/DONE sequencer owning the shared single-port data RAM
module dram_access_sequencer
   import dram_seq_pkg::*;
#(
   parameter int               ADDR_W    = DEF_ADDR_W,
   parameter int               DATA_W    = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] LOAD_BASE = '0,
   parameter int               LOAD_LEN  = 256,
   parameter logic [ADDR_W-1:0] DUMP_BASE = '0,
   parameter int               DUMP_LEN  = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rx_valid,
   input  logic [DATA_W-1:0]   rx_data,
   input  logic [ADDR_W-1:0]   proc_address,
   input  logic [DATA_W-1:0]   proc_wdata,
   input  logic                proc_wren,
   input  logic                proc_done,
   output logic                proc_enable,
   output logic [ADDR_W-1:0]   dram_address,
   output logic [DATA_W-1:0]   dram_data,
   output logic                dram_wren,
   input  logic [DATA_W-1:0]   dram_q,
   input  logic                tx_ready,
   output logic                tx_start,
   output logic [DATA_W-1:0]   tx_data,
   output logic [1:0]          phase
);

   // ptr carries one extra bit so a full 2^ADDR_W dump count is representable.
   localparam int               LOAD_LAST_I = LOAD_LEN - 1;
   localparam int               DUMP_END_I  = DUMP_LEN;
   localparam logic [ADDR_W:0]  LOAD_LAST   = LOAD_LAST_I[ADDR_W:0];
   localparam logic [ADDR_W:0]  DUMP_END    = DUMP_END_I[ADDR_W:0];

   state_t              state_q;
   logic [ADDR_W:0]     ptr_q;
   logic                proc_enable_q;
   logic                tx_start_q;
   logic [DATA_W-1:0]   tx_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_LOAD;
         ptr_q         <= '0;
         proc_enable_q <= 1'b0;
         tx_start_q    <= 1'b0;
         tx_data_q     <= '0;
      end else begin
         tx_start_q <= 1'b0;
         unique case (state_q)
            S_LOAD: begin
               if (rx_valid) begin
                  if (ptr_q == LOAD_LAST) begin
                     state_q       <= S_RUN;
                     ptr_q         <= '0;
                     proc_enable_q <= 1'b1;
                  end else begin
                     ptr_q <= ptr_q + 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (proc_done) begin
                  state_q       <= S_DUMP_ADDR;
                  proc_enable_q <= 1'b0;
               end
            end
            S_DUMP_ADDR: state_q <= S_DUMP_WAIT;
            S_DUMP_WAIT: state_q <= S_DUMP_SEND;
            S_DUMP_SEND: begin
               if (tx_ready) begin
                  tx_data_q  <= dram_q;
                  tx_start_q <= 1'b1;
                  ptr_q      <= ptr_q + 1'b1;
                  state_q    <= S_DUMP_GAP;
               end
            end
            // tx_ready is still stale here: the transmitter drops it only after seeing the pulse.
            S_DUMP_GAP: state_q <= (ptr_q == DUMP_END) ? S_DONE : S_DUMP_ADDR;
            S_DONE:     state_q <= S_DONE;
            default:    state_q <= S_LOAD;
         endcase
      end
   end

   dram_port_mux #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .LOAD_BASE (LOAD_BASE),
      .DUMP_BASE (DUMP_BASE)
   ) u_mux (
      .state        (state_q),
      .ptr          (ptr_q[ADDR_W-1:0]),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .proc_address (proc_address),
      .proc_wdata   (proc_wdata),
      .proc_wren    (proc_wren),
      .dram_address (dram_address),
      .dram_data    (dram_data),
      .dram_wren    (dram_wren)
   );

   assign proc_enable = proc_enable_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign phase       = phase_of(state_q);

endmodule

// File: tb/tb_dram_access_sequencer.sv
// tb/tb_dram_access_sequencer.sv - directed self-checking bench for dram_access_sequencer
module tb_dram_access_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, rst_n_w;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic [15:0] proc_address;
   logic [7:0]  proc_wdata;
   logic        proc_wren, proc_done, tx_ready;

   logic        proc_enable, dram_wren, tx_start;
   logic [15:0] dram_address;
   logic [7:0]  dram_data, dram_q, tx_data;
   logic [1:0]  phase;

   logic        w_proc_enable, w_dram_wren, w_tx_start;
   logic [15:0] w_dram_address;
   logic [7:0]  w_dram_data, w_tx_data;
   logic [1:0]  w_phase;

   logic [7:0]  mem [0:65535];
   logic [7:0]  mem_q;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          log_n = 0;
   int          stamp [0:15];
   logic [7:0]  ldat [0:15];
   int          base;
   logic [15:0] wexp [0:3];

   always #5 clk = ~clk;

   dram_access_sequencer #(
      .ADDR_W(16), .DATA_W(8), .LOAD_BASE(16'h0100), .LOAD_LEN(4),
      .DUMP_BASE(16'h0100), .DUMP_LEN(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .proc_address(proc_address), .proc_wdata(proc_wdata), .proc_wren(proc_wren),
      .proc_done(proc_done), .proc_enable(proc_enable), .dram_address(dram_address),
      .dram_data(dram_data), .dram_wren(dram_wren), .dram_q(dram_q),
      .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data), .phase(phase)
   );

   dram_access_sequencer #(
      .ADDR_W(16), .DATA_W(8), .LOAD_BASE(16'hFFFE), .LOAD_LEN(4),
      .DUMP_BASE(16'h0000), .DUMP_LEN(4)
   ) u_wrap (
      .clk(clk), .rst_n(rst_n_w), .rx_valid(rx_valid), .rx_data(rx_data),
      .proc_address(proc_address), .proc_wdata(proc_wdata), .proc_wren(proc_wren),
      .proc_done(proc_done), .proc_enable(w_proc_enable), .dram_address(w_dram_address),
      .dram_data(w_dram_data), .dram_wren(w_dram_wren), .dram_q(8'h00),
      .tx_ready(tx_ready), .tx_start(w_tx_start), .tx_data(w_tx_data), .phase(w_phase)
   );

   // Single-port RAM with one-cycle read latency.
   always @(posedge clk) begin
      if (dram_wren) mem[dram_address] <= dram_data;
      mem_q <= mem[dram_address];
   end
   assign dram_q = mem_q;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_start && log_n < 16) begin
         stamp[log_n] <= cyc;
         ldat[log_n]  <= tx_data;
         log_n        <= log_n + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_pulses(input int n, input int bound);
      int k = 0;
      while (log_n < n && k < bound) begin
         @(negedge clk);
         k++;
      end
      check("pulse_wait", 32'(log_n >= n), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; rst_n_w = 1'b0;
      rx_valid = 1'b0; rx_data = 8'h00;
      proc_address = 16'h0000; proc_wdata = 8'h00; proc_wren = 1'b0;
      proc_done = 1'b0; tx_ready = 1'b1;
      wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000; wexp[3] = 16'h0001;

      #3;
      check("rst_phase", 32'(phase), 32'd0);
      check("rst_proc_enable", 32'(proc_enable), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_dram_wren", 32'(dram_wren), 32'd0);
      check("rst_dram_address", 32'(dram_address), 32'h0100);
      @(negedge clk);
      rst_n = 1'b1;

      // Load four bytes with irregular gaps.
      send_rx(8'hA1, 1);
      send_rx(8'hB2, 3);
      send_rx(8'hC3, 0);
      check("load_phase_before_last", 32'(phase), 32'd0);
      send_rx(8'hD4, 2);
      check("load_phase_run", 32'(phase), 32'd1);
      check("load_proc_enable", 32'(proc_enable), 32'd1);
      check("mem_0100", 32'(mem[16'h0100]), 32'hA1);
      check("mem_0101", 32'(mem[16'h0101]), 32'hB2);
      check("mem_0102", 32'(mem[16'h0102]), 32'hC3);
      check("mem_0103", 32'(mem[16'h0103]), 32'hD4);

      // Processor pass-through.
      proc_address = 16'h0200; proc_wdata = 8'h5A; proc_wren = 1'b1;
      #1;
      check("run_addr", 32'(dram_address), 32'h0200);
      check("run_data", 32'(dram_data), 32'h5A);
      check("run_wren", 32'(dram_wren), 32'd1);
      @(negedge clk);
      proc_wren = 1'b0; rx_data = 8'hEE; rx_valid = 1'b1;
      #1;
      check("run_rx_no_wren", 32'(dram_wren), 32'd0);
      @(negedge clk);
      rx_valid = 1'b0;
      check("run_mem_0200", 32'(mem[16'h0200]), 32'h5A);
      check("run_phase_hold", 32'(phase), 32'd1);

      // Dump with tx_ready held high.
      base = log_n;
      proc_done = 1'b1;
      @(negedge clk);
      check("dump_proc_enable_fall", 32'(proc_enable), 32'd0);
      check("dump_phase", 32'(phase), 32'd2);
      wait_pulses(base + 3, 60);
      check("dump_byte0", 32'(ldat[base]), 32'hA1);
      check("dump_byte1", 32'(ldat[base+1]), 32'hB2);
      check("dump_byte2", 32'(ldat[base+2]), 32'hC3);
      check("dump_gap01", 32'(stamp[base+1] - stamp[base]), 32'd4);
      check("dump_gap12", 32'(stamp[base+2] - stamp[base+1]), 32'd4);
      check("done_phase", 32'(phase), 32'd3);
      proc_done = 1'b0; rx_valid = 1'b1; rx_data = 8'h99;
      #1;
      check("done_no_wren", 32'(dram_wren), 32'd0);
      @(negedge clk);
      rx_valid = 1'b0;
      check("done_phase_hold", 32'(phase), 32'd3);
      check("done_tx_data_hold", 32'(tx_data), 32'hC3);

      // Second run: proc_done already high on RUN entry, then back-pressure.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      proc_done = 1'b1;
      send_rx(8'hA1, 0);
      send_rx(8'hB2, 2);
      send_rx(8'hC3, 1);
      send_rx(8'hD4, 0);
      check("run2_phase_run", 32'(phase), 32'd1);
      @(negedge clk);
      check("run2_one_cycle_run", 32'(phase), 32'd2);
      base = log_n;
      wait_pulses(base + 1, 20);
      tx_ready = 1'b0;
      repeat (20) @(negedge clk);
      check("bp_no_second_pulse", 32'(log_n - base), 32'd1);
      check("bp_tx_data_hold", 32'(tx_data), 32'hA1);
      tx_ready = 1'b1;
      wait_pulses(base + 2, 20);
      check("bp_byte0", 32'(ldat[base]), 32'hA1);
      check("bp_byte1", 32'(ldat[base+1]), 32'hB2);
      check("bp_spacing", 32'(stamp[base+1] - stamp[base]), 32'd22);

      // Asynchronous reset mid-dump.
      #2 rst_n = 1'b0;
      #1;
      check("arst_phase", 32'(phase), 32'd0);
      check("arst_tx_data", 32'(tx_data), 32'd0);
      check("arst_tx_start", 32'(tx_start), 32'd0);
      check("arst_proc_enable", 32'(proc_enable), 32'd0);
      check("arst_dram_wren", 32'(dram_wren), 32'd0);
      check("arst_dram_address", 32'(dram_address), 32'h0100);
      proc_done = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send_rx(8'h77, 1);
      check("arst_reload_mem", 32'(mem[16'h0100]), 32'h77);
      check("arst_reload_phase", 32'(phase), 32'd0);
      check("arst_pulse_count", 32'(log_n - base), 32'd2);

      // Address wrap on the second instance.
      rst_n_w = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rx_data  = 8'h10 + 8'(i);
         rx_valid = 1'b1;
         #1;
         check("wrap_addr", 32'(w_dram_address), 32'(wexp[i]));
         check("wrap_wren", 32'(w_dram_wren), 32'd1);
      end
      @(negedge clk);
      rx_valid = 1'b0;
      check("wrap_phase_run", 32'(w_phase), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
